// File: rtl/uart_core.sv
// uart_core: single-clock UART transceiver with valid/ready byte interfaces.
//
// An internal divider produces OVERSAMPLE ticks per bit from the system clock,
// so one bit period is DIV*OVERSAMPLE clocks, where
// DIV = round(CLK_HZ / (BAUD*OVERSAMPLE)).
// The frame is sent LSB first: a start bit (0), then DATA_BITS data bits, then
// an optional parity bit, then STOP_BITS stop bits (1).
//
// Ports:
//   clk, rst_n       system clock; synchronous active-low reset
//   tx_data/valid    byte to send, accepted when tx_valid && tx_ready
//   tx_ready         transmitter idle
//   txd              serial output, idles high
//   rxd              asynchronous serial input
//   loopback         (only with UART_LOOPBACK_EN) routes internal TX into RX
//                    and holds txd high
//   rx_data/valid    one-entry holding register, consumed by rx_ready
//   rx_frame_err     first stop bit sampled low for the held byte
//   rx_parity_err    parity mismatch for the held byte
//   rx_overrun       sticky; a frame was dropped while rx_valid was high
//
// Optional feature macro: UART_LOOPBACK_EN
module uart_core #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int DIV    = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  // Parity bit to transmit (or expect) for a payload: odd makes the total
  // count of ones odd, even makes it even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t            tx_state;
  logic [DIV_W-1:0]     tx_div;
  logic [TICK_W-1:0]    tx_tick;
  logic [3:0]           tx_bcnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_line;
  logic                 tx_bit_end;

  rx_state_t            rx_state;
  logic                 rx_in;
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_prev;
  logic [DIV_W-1:0]     rx_div;
  logic [TICK_W-1:0]    rx_tick;
  logic [3:0]           rx_bcnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic                 rx_sample;

  logic                 frame_vld_p0;
  logic [DATA_BITS-1:0] frame_data_p0;
  logic                 frame_ferr_p0;
  logic                 frame_perr_p0;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_line : rxd;
  assign txd   = loopback ? 1'b1 : tx_line;
`else
  assign rx_in = rxd;
  assign txd   = tx_line;
`endif

  assign tx_bit_end = (tx_div == DIV_W'(DIV - 1)) && (tx_tick == TICK_W'(OVERSAMPLE - 1));

  // The start bit is checked at its middle; after that, each sample lands
  // one full bit later, which is also mid-bit.
  assign rx_sample = (rx_div == DIV_W'(DIV - 1)) &&
                     (rx_tick == ((rx_state == RX_START) ? TICK_W'(OVERSAMPLE / 2 - 1)
                                                         : TICK_W'(OVERSAMPLE - 1)));

  // Transmit FSM; tx_line is registered so txd changes on the clock edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_ready <= 1'b1;
      tx_line  <= 1'b1;
      tx_div   <= '0;
      tx_tick  <= '0;
      tx_bcnt  <= '0;
    end else begin
      if (tx_div == DIV_W'(DIV - 1)) begin
        tx_div  <= '0;
        tx_tick <= (tx_tick == TICK_W'(OVERSAMPLE - 1)) ? '0 : tx_tick + 1'b1;
      end else begin
        tx_div <= tx_div + 1'b1;
      end
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_shift <= tx_data;
            tx_par   <= parity_bit(tx_data);
            tx_ready <= 1'b0;
            tx_line  <= 1'b0;
            tx_div   <= '0;
            tx_tick  <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bcnt  <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bcnt == 4'(DATA_BITS - 1)) begin
              tx_bcnt <= '0;
              if (PARITY != 0) begin
                tx_line  <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx_line  <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bcnt  <= tx_bcnt + 1'b1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_line  <= 1'b1;
            tx_bcnt  <= '0;
            tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_bcnt == 4'(STOP_BITS - 1)) begin
              tx_ready <= 1'b1;
              tx_line  <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_bcnt <= tx_bcnt + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receive synchronizer and FSM; a finished frame is handed on as stage p0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_div       <= '0;
      rx_tick      <= '0;
      rx_bcnt      <= '0;
      frame_vld_p0 <= 1'b0;
    end else begin
      rx_s1        <= rx_in;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      frame_vld_p0 <= 1'b0;
      if (rx_div == DIV_W'(DIV - 1)) begin
        rx_div  <= '0;
        rx_tick <= rx_sample ? '0 : rx_tick + 1'b1;
      end else begin
        rx_div <= rx_div + 1'b1;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_div   <= '0;
            rx_tick  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            rx_bcnt  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_bcnt == 4'(DATA_BITS - 1)) begin
              rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bcnt <= rx_bcnt + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_par_bit <= rx_s2;
            rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            frame_vld_p0  <= 1'b1;
            frame_data_p0 <= rx_shift;
            frame_ferr_p0 <= !rx_s2;
            frame_perr_p0 <= (PARITY != 0) && (parity_bit(rx_shift) != rx_par_bit);
            // A low stop bit means a break or a framing error: wait for the
            // line to go high before hunting for the next start edge.
            rx_state      <= rx_s2 ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Holding register; a new load takes priority over a consumer handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (frame_vld_p0) begin
      if (!rx_valid || rx_ready) begin
        rx_data       <= frame_data_p0;
        rx_frame_err  <= frame_ferr_p0;
        rx_parity_err <= frame_perr_p0;
        rx_valid      <= 1'b1;
        if (rx_valid && rx_ready) rx_overrun <= 1'b0;
      end else begin
        rx_overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: two instances (8N1 and 8E1) at DIV = 4, 64 clocks/bit.
module tb_uart_core;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 15625;
  localparam int BITC   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data_a, rx_data_a, tx_data_b, rx_data_b;
  logic       tx_valid_a, tx_ready_a, txd_a, rxd_a, rx_valid_a, rx_ready_a;
  logic       rx_ferr_a, rx_perr_a, rx_ovr_a;
  logic       tx_valid_b, tx_ready_b, txd_b, rxd_b, rx_valid_b, rx_ready_b;
  logic       rx_ferr_b, rx_perr_b, rx_ovr_b;
`ifdef UART_LOOPBACK_EN
  logic       lb_a, lb_b;
`endif

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
              .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .txd(txd_a), .rxd(rxd_a),
`ifdef UART_LOOPBACK_EN
    .loopback(lb_a),
`endif
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_frame_err(rx_ferr_a), .rx_parity_err(rx_perr_a), .rx_overrun(rx_ovr_a));

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
              .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .txd(txd_b), .rxd(rxd_b),
`ifdef UART_LOOPBACK_EN
    .loopback(lb_b),
`endif
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_frame_err(rx_ferr_b), .rx_parity_err(rx_perr_b), .rx_overrun(rx_ovr_b));

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       ovr;
  } rx_exp_t;

  rx_exp_t    rxa_q[$];
  rx_exp_t    rxb_q[$];
  logic [9:0] txq[$];
  int         checks = 0;
  int         errors = 0;
  bit         tx_mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_rx(input string tag, input rx_exp_t e, input logic [7:0] d,
                        input logic fe, input logic pe, input logic ov);
    chk({tag, "_data"}, int'(d), int'(e.data));
    chk({tag, "_frame_err"}, int'(fe), int'(e.ferr));
    chk({tag, "_parity_err"}, int'(pe), int'(e.perr));
    chk({tag, "_overrun"}, int'(ov), int'(e.ovr));
  endtask

  // RX monitors: a byte is consumed at the edge after valid && ready is seen
  rx_exp_t ea, eb;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid_a && rx_ready_a) begin
      if (rxa_q.size() == 0) chk("rxa_unexpected_byte", int'(rx_data_a), -1);
      else begin
        ea = rxa_q.pop_front();
        cmp_rx("rxa", ea, rx_data_a, rx_ferr_a, rx_perr_a, rx_ovr_a);
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid_b && rx_ready_b) begin
      if (rxb_q.size() == 0) chk("rxb_unexpected_byte", int'(rx_data_b), -1);
      else begin
        eb = rxb_q.pop_front();
        cmp_rx("rxb", eb, rx_data_b, rx_ferr_b, rx_perr_b, rx_ovr_b);
      end
    end
  end

  // TX monitor: every level of an expected frame must hold for BITC clocks
  logic [9:0] tf;
  int         bad, rbad;
  always begin
    @(negedge clk);
    if (tx_mon_en && rst_n === 1'b1 && txd_a === 1'b0) begin
      if (txq.size() == 0) begin
        chk("tx_unexpected_frame", 1, 0);
        repeat (12 * BITC) @(negedge clk);
      end else begin
        tf   = txq.pop_front();
        rbad = 0;
        for (int b = 0; b < 10; b++) begin
          bad = 0;
          for (int s = 0; s < BITC; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (txd_a !== tf[b]) bad++;
            if (tx_ready_a !== 1'b0) rbad++;
          end
          chk($sformatf("tx_bit%0d_bad_samples", b), bad, 0);
        end
        chk("tx_ready_low_samples", rbad, 0);
        @(negedge clk);
        chk("tx_ready_return", int'(tx_ready_a), 1);
      end
    end
  end

  task automatic send_tx(input logic [7:0] d, input bit push, input bit line_chk);
    int n = 0;
    @(posedge clk); #1;
    while (!tx_ready_a && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tx_ready_a) begin
      chk("tx_ready_timeout", 0, 1);
      return;
    end
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    if (push) txq.push_back({1'b1, d, 1'b0});
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
    @(negedge clk);
    if (line_chk) chk("tx_start_latency", int'(txd_a), 0);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    @(posedge clk); #1;
    while (!tx_ready_a && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tx_idle_timeout", int'(tx_ready_a), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input bit which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) rxd_b = bits[i];
      else       rxd_a = bits[i];
      repeat (BITC) @(posedge clk);
      #1;
    end
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  // Reference model: a frame arriving while the previous byte is still held
  // and the consumer is stalled is dropped and marks the held byte overrun.
  task automatic send_rx_a(input logic [7:0] d, input bit stop_ok);
    rx_exp_t e;
    e.data = d; e.ferr = !stop_ok; e.perr = 1'b0; e.ovr = 1'b0;
    if (!rx_ready_a && rxa_q.size() > 0) begin
      e = rxa_q.pop_back();
      e.ovr = 1'b1;
      rxa_q.push_back(e);
    end else begin
      rxa_q.push_back(e);
    end
    drive_rx(1'b0, {6'b0, stop_ok, d, 1'b0}, 10);
  endtask

  task automatic send_rx_b(input logic [7:0] d, input bit par_ok, input bit stop_ok);
    rx_exp_t e;
    logic    p;
    p = (^d) ^ !par_ok;
    e.data = d; e.ferr = !stop_ok; e.perr = !par_ok; e.ovr = 1'b0;
    rxb_q.push_back(e);
    drive_rx(1'b1, {5'b0, stop_ok, p, d, 1'b0}, 11);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rxa_q.size() + rxb_q.size()) != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rx_drain_pending", rxa_q.size() + rxb_q.size(), 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    rst_n = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; rxd_a = 1'b1; rx_ready_a = 1'b1;
    tx_data_b = '0; tx_valid_b = 1'b0; rxd_b = 1'b1; rx_ready_b = 1'b1;
`ifdef UART_LOOPBACK_EN
    lb_a = 1'b0; lb_b = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_ready", int'(tx_ready_a), 1);
    chk("reset_txd", int'(txd_a), 1);
    chk("reset_rx_valid", int'(rx_valid_a), 0);
    chk("reset_rx_data", int'(rx_data_a), 0);
    chk("reset_frame_err", int'(rx_ferr_a), 0);
    chk("reset_parity_err", int'(rx_perr_a), 0);
    chk("reset_overrun", int'(rx_ovr_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_mon_en = 1'b1;

    // TX 8N1, a request while busy, then back-to-back random bytes
    send_tx(8'hA5, 1'b1, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    tx_data_a = 8'hFF; tx_valid_a = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tx_valid_a = 1'b0;
    chk("tx_busy_ready_low", int'(tx_ready_a), 0);
    for (int i = 0; i < 3; i++) send_tx(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    wait_tx_idle();

    // Reset during data bit 3
    tx_mon_en = 1'b0;
    send_tx(8'h5A, 1'b0, 1'b1);
    repeat (4 * BITC + 20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midframe_reset_txd", int'(txd_a), 1);
    chk("midframe_reset_tx_ready", int'(tx_ready_a), 1);
    rst_n = 1'b1;
    tx_mon_en = 1'b1;
    send_tx(8'h55, 1'b1, 1'b1);
    wait_tx_idle();

    // RX even parity: good parity then bad parity
    send_rx_b(8'h3C, 1'b1, 1'b1);
    wait_drain();
    send_rx_b(8'h3C, 1'b0, 1'b1);
    wait_drain();

    // Glitch: false start, then a real frame proves the FSM recovered
    rxd_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rxd_a = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    chk("glitch_no_valid", int'(rx_valid_a), 0);
    send_rx_a(8'hC3, 1'b1);
    wait_drain();

    // Break: one 0x00 with frame error, nothing more while the line stays low
    begin
      rx_exp_t e;
      e.data = 8'h00; e.ferr = 1'b1; e.perr = 1'b0; e.ovr = 1'b0;
      rxa_q.push_back(e);
    end
    rxd_a = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    chk("break_one_byte_consumed", rxa_q.size(), 0);
    rxd_a = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    chk("break_no_more_valid", int'(rx_valid_a), 0);

    // Overrun with the consumer stalled
    rx_ready_a = 1'b0;
    send_rx_a(8'h11, 1'b1);
    send_rx_a(8'h22, 1'b1);
    chk("overrun_valid_held", int'(rx_valid_a), 1);
    chk("overrun_data_first", int'(rx_data_a), 8'h11);
    chk("overrun_flag_set", int'(rx_ovr_a), 1);
    rx_ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("overrun_valid_cleared", int'(rx_valid_a), 0);
    chk("overrun_flag_cleared", int'(rx_ovr_a), 0);
    wait_drain();

    // Randomized traffic on all paths
    for (int i = 0; i < 6; i++) begin
      send_tx(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      wait_tx_idle();
      send_rx_a(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      wait_drain();
      send_rx_b(8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 3) != 0));
      wait_drain();
    end

`ifdef UART_LOOPBACK_EN
    lb_a = 1'b1;
    begin
      rx_exp_t e;
      e.data = 8'h96; e.ferr = 1'b0; e.perr = 1'b0; e.ovr = 1'b0;
      rxa_q.push_back(e);
    end
    lowcnt = 0;
    fork
      send_tx(8'h96, 1'b0, 1'b0);
      for (int k = 0; k < 12 * BITC; k++) begin
        @(negedge clk);
        if (txd_a !== 1'b1) lowcnt++;
      end
    join
    chk("loopback_txd_held_high", lowcnt, 0);
    wait_drain();
    lb_a = 1'b0;
`else
    lowcnt = 0;
`endif

    wait_tx_idle();
    wait_drain();
    chk("tx_queue_empty", txq.size() + lowcnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
